// File: rtl/mmio_periph_responder.sv
// MMIO responder for the MEM-stage port: timer (TH/TL/TCON), LED, 7-seg DIGIT, SysTick.
// Latency: reads are combinational (0 cycles); writes land on the next rising clk edge.
// Backpressure: none; every access completes in its own cycle, Hit steers the top-level load mux.
module mmio_periph_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LED_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Address,
  input  logic [31:0]      Write_data,
  input  logic             MemRead,
  input  logic             MemWrite,
  output logic [31:0]      Read_data,
  output logic             Hit,
  output logic [LED_W-1:0] led,
  output logic [7:0]       BCD,
  output logic [3:0]       AN,
  output logic             irq
);

  localparam logic [2:0] OFF_TH      = 3'd0;
  localparam logic [2:0] OFF_TL      = 3'd1;
  localparam logic [2:0] OFF_TCON    = 3'd2;
  localparam logic [2:0] OFF_LED     = 3'd3;
  localparam logic [2:0] OFF_DIGIT   = 3'd4;
  localparam logic [2:0] OFF_SYSTICK = 3'd5;

  logic [31:0]      th_q, th_d;
  logic [31:0]      tl_q, tl_d;
  logic [2:0]       tcon_q, tcon_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [11:0]      digit_q, digit_d;
  logic [31:0]      systick_q, systick_d;

  logic [2:0] offset;
  logic       wr_th, wr_tl, wr_tcon, wr_led, wr_digit;
  logic       tl_at_max;

  assign offset = Address[4:2];

  // Address decode: inside the 32-byte window, word aligned, and one of the six mapped words
  always_comb begin
    Hit = (Address[31:5] == BASE_ADDR[31:5]) && (Address[1:0] == 2'b00) && (offset <= OFF_SYSTICK);
  end

  assign wr_th    = MemWrite && Hit && (offset == OFF_TH);
  assign wr_tl    = MemWrite && Hit && (offset == OFF_TL);
  assign wr_tcon  = MemWrite && Hit && (offset == OFF_TCON);
  assign wr_led   = MemWrite && Hit && (offset == OFF_LED);
  assign wr_digit = MemWrite && Hit && (offset == OFF_DIGIT);
  assign tl_at_max = (tl_q == 32'hFFFF_FFFF);

  // Next-state: hardware timer/systick update first, then a CPU write overrides the whole register
  always_comb begin
    th_d      = th_q;
    tl_d      = tl_q;
    tcon_d    = tcon_q;
    led_d     = led_q;
    digit_d   = digit_q;
    systick_d = systick_q + 32'd1;

    if (tcon_q[0]) begin
      if (!tl_at_max) begin
        tl_d = tl_q + 32'd1;
      end else begin
        tl_d = th_q;
        // a same-cycle TL store cancels the overflow, so no status either
        if (tcon_q[1] && !wr_tl) begin
          tcon_d[2] = 1'b1;
        end
      end
    end

    if (wr_th)    th_d    = Write_data;
    if (wr_tl)    tl_d    = Write_data;
    if (wr_tcon)  tcon_d  = Write_data[2:0];
    if (wr_led)   led_d   = Write_data[LED_W-1:0];
    if (wr_digit) digit_d = Write_data[11:0];
  end

  // State registers; DIGIT resets to all-ones so the active-low display starts dark
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q      <= 32'd0;
      tl_q      <= 32'd0;
      tcon_q    <= 3'd0;
      led_q     <= '0;
      digit_q   <= 12'hFFF;
      systick_q <= 32'd0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      digit_q   <= digit_d;
      systick_q <= systick_d;
    end
  end

  // Read mux: zero-extended register value on a hit load, otherwise zero
  always_comb begin
    Read_data = 32'd0;
    if (MemRead && Hit) begin
      case (offset)
        OFF_TH:      Read_data = th_q;
        OFF_TL:      Read_data = tl_q;
        OFF_TCON:    Read_data = {29'd0, tcon_q};
        OFF_LED:     Read_data = 32'(led_q);
        OFF_DIGIT:   Read_data = {20'd0, digit_q};
        OFF_SYSTICK: Read_data = systick_q;
        default:     Read_data = 32'd0;
      endcase
    end
  end

  assign led = led_q;
  assign BCD = digit_q[7:0];
  assign AN  = digit_q[11:8];
  assign irq = tcon_q[2];

endmodule

// File: tb/tb_mmio_periph_responder.sv
// Directed bench for mmio_periph_responder with a read-expectation scoreboard.
// Latency: reads sampled 1ns after drive in the clock low phase; writes take one edge.
// Backpressure: none exercised; the DUT accepts every access.
module tb_mmio_periph_responder;

  localparam logic [31:0] A_TH      = 32'h4000_0000;
  localparam logic [31:0] A_TL      = 32'h4000_0004;
  localparam logic [31:0] A_TCON    = 32'h4000_0008;
  localparam logic [31:0] A_LED     = 32'h4000_000C;
  localparam logic [31:0] A_DIGIT   = 32'h4000_0010;
  localparam logic [31:0] A_SYSTICK = 32'h4000_0014;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Address = 32'd0;
  logic [31:0] Write_data = 32'd0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Read_data;
  logic        Hit;
  logic [15:0] led;
  logic [7:0]  BCD;
  logic [3:0]  AN;
  logic        irq;

  typedef struct {
    logic [31:0] data;
    logic        hit;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int unsigned cyc;    // reference SysTick: rising edges since reset release

  mmio_periph_responder #(.BASE_ADDR(32'h4000_0000), .LED_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Read_data  (Read_data),
    .Hit        (Hit),
    .led        (led),
    .BCD        (BCD),
    .AN         (AN),
    .irq        (irq)
  );

  always #10 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // load: expectation enters the scoreboard when the access is driven, retired when sampled
  task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_h, input string tag);
    exp_t e;
    sb.push_back('{data: exp_d, hit: exp_h});
    Address = a;
    MemRead = 1'b1;
    #1;
    e = sb.pop_front();
    check({tag, ".data"}, Read_data, e.data);
    check({tag, ".hit"}, {31'd0, Hit}, {31'd0, e.hit});
    MemRead = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address    = a;
    Write_data = d;
    MemWrite   = 1'b1;
    @(negedge clk);
    MemWrite   = 1'b0;
  endtask

  logic [31:0] bad_addr[5];

  initial begin
    bad_addr = '{32'h4000_0018, 32'h4000_001C, 32'h4000_0002, 32'h4000_0020, 32'h1001_0000};

    // power-on reset
    tick(2);
    check("por.led", {16'd0, led}, 32'd0);
    check("por.an_bcd", {20'd0, AN, BCD}, 32'h0000_0FFF);
    reset = 1'b1;

    // peripherals
    wr(A_LED, 32'h0000_A5A5);
    wr(A_DIGIT, 32'h0000_0E3F);
    check("led", {16'd0, led}, 32'h0000_A5A5);
    check("an", {28'd0, AN}, 32'h0000_000E);
    check("bcd", {24'd0, BCD}, 32'h0000_003F);
    rd(A_LED, 32'h0000_A5A5, 1'b1, "rd_led");
    rd(A_DIGIT, 32'h0000_0E3F, 1'b1, "rd_digit");
    wr(A_SYSTICK, 32'd0);
    rd(A_SYSTICK, cyc, 1'b1, "systick_ro");
    // read and write together: load returns the pre-write value
    Address = A_LED; Write_data = 32'h0000_1234; MemRead = 1'b1; MemWrite = 1'b1;
    #1 check("rw_same_cycle", Read_data, 32'h0000_A5A5);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    check("rw_after", {16'd0, led}, 32'h0000_1234);

    // mid-run reset with the timer counting and irq enabled
    wr(A_TH, 32'h1234_5678);
    wr(A_TCON, 32'd3);
    tick(3);
    reset = 1'b0;
    #1;
    check("rst.led", {16'd0, led}, 32'd0);
    check("rst.an", {28'd0, AN}, 32'h0000_000F);
    check("rst.bcd", {24'd0, BCD}, 32'h0000_00FF);
    check("rst.irq", {31'd0, irq}, 32'd0);
    tick(2);
    reset = 1'b1;
    rd(A_TH, 32'd0, 1'b1, "rst_th");
    rd(A_TL, 32'd0, 1'b1, "rst_tl");
    rd(A_TCON, 32'd0, 1'b1, "rst_tcon");
    rd(A_LED, 32'd0, 1'b1, "rst_led");
    rd(A_DIGIT, 32'h0000_0FFF, 1'b1, "rst_digit");
    rd(A_SYSTICK, 32'd0, 1'b1, "systick0");
    tick(1);
    rd(A_SYSTICK, 32'd1, 1'b1, "systick1");
    tick(1);
    rd(A_SYSTICK, 32'd2, 1'b1, "systick2");

    // overflow and reload; edge N is the TCON write
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'd3);
    rd(A_TL, 32'hFFFF_FFFE, 1'b1, "ovf_n");
    tick(1);
    rd(A_TL, 32'hFFFF_FFFF, 1'b1, "ovf_n1");
    check("ovf_n1.irq", {31'd0, irq}, 32'd0);
    tick(1);
    rd(A_TL, 32'hFFFF_FFFC, 1'b1, "ovf_n2");
    check("ovf_n2.irq", {31'd0, irq}, 32'd1);
    tick(4);
    rd(A_TL, 32'hFFFF_FFFC, 1'b1, "ovf_n6");
    wr(A_TCON, 32'd3);
    check("irq_clr", {31'd0, irq}, 32'd0);
    rd(A_TL, 32'hFFFF_FFFD, 1'b1, "count_on");
    rd(A_TCON, 32'd3, 1'b1, "tcon_after_clr");

    // collision: TL store on the overflow edge
    tick(2);
    rd(A_TL, 32'hFFFF_FFFF, 1'b1, "pre_coll");
    wr(A_TL, 32'h0000_0010);
    rd(A_TL, 32'h0000_0010, 1'b1, "coll_tl");
    check("coll_irq", {31'd0, irq}, 32'd0);
    tick(1);
    rd(A_TL, 32'h0000_0011, 1'b1, "coll_next");

    // decode: unmapped, misaligned and foreign addresses
    foreach (bad_addr[i]) begin
      wr(bad_addr[i], 32'hFFFF_FFFF);
      rd(bad_addr[i], 32'd0, 1'b0, $sformatf("bad_%h", bad_addr[i]));
    end
    rd(A_TH, 32'hFFFF_FFFC, 1'b1, "bad_th_kept");
    rd(A_TCON, 32'd3, 1'b1, "bad_tcon_kept");
    rd(A_LED, 32'd0, 1'b1, "bad_led_kept");
    rd(A_DIGIT, 32'h0000_0FFF, 1'b1, "bad_digit_kept");
    rd(A_SYSTICK, cyc, 1'b1, "systick_hit");

    // enable off: irq enable alone must not move TL
    wr(A_TCON, 32'd2);
    wr(A_TL, 32'd5);
    tick(100);
    rd(A_TL, 32'd5, 1'b1, "en_off_tl");
    check("en_off_irq", {31'd0, irq}, 32'd0);

    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
